vdc_regbank: RTL
================

// Module: vdc_regbank
// PURPOSE
//  Parametrised CPU-side register bank for the VDC family; supersedes the fixed 38-register decode.
//  Holds index (select) reg, status reg and NUM_REGS x 8-bit control regs, exported flat to the video/RAM engines.
//  Adds a write-pending FIFO so data writes during busy are deferred, not dropped.
//  Adds optional index auto-increment and per-bit implemented/read-only masks.
// PARAMETERS
//  NUM_REGS    38     number of indexed registers (2..256)
//  PEND_DEPTH  2      write-pending FIFO depth (power of 2, >=1)
//  RESET_VAL   {NUM_REGS*8{1'b0}}  per-register reset value, reg i at bits [8i+7:8i]
//  IMPL_MASK   {NUM_REGS*8{1'b1}}  1 = bit implemented; 0 = ignores writes, reads 1
//  EXT_MASK    {NUM_REGS{1'b0}}    1 = register owned externally (read via ext_rdata, write via ext_wr)
//  DATA_IDX    31     index exempt from auto-increment (RAM data port)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous reset, active low
//  cs           in   1   chip select, one-clk pulse per CPU access
//  rs           in   1   0 = index/status, 1 = data
//  we           in   1   1 = write, 0 = read
//  db_in        in   8   CPU write data
//  db_out       out  8   CPU read data (registered)
//  version      in   2   chip version, returned in status[1:0]
//  autoinc      in   1   enable index auto-increment after data accesses
//  busy         in   1   RAM engine busy
//  vsync        in   1   vertical sync, returned in status[5]
//  lp_strobe    in   1   light-pen trigger, sets sticky status[6]
//  ext_rdata    in   8   read data for EXT_MASK register at ext_idx
//  ext_idx      out  8   current index register (combinational copy)
//  ext_wr       out  1   one-clk write strobe for EXT_MASK register
//  ext_widx     out  8   index accompanying ext_wr
//  ext_wdata    out  8   data accompanying ext_wr
//  regs         out  NUM_REGS*8  flat register contents
//  pend_ovf     out  1   sticky: write dropped, FIFO full
// BEHAVIOUR
//  Reset (async, reset_n=0): index=0, regs=RESET_VAL, db_out=8'h00, lp=0, FIFO empty, pend_ovf=0, ext_wr=0.
//  Index write (cs&we&!rs): index<=db_in next clk; never deferred, even while busy.
//  Status read (cs&!we&!rs): db_out<={~busy,lp,vsync,3'b000,version}; lp cleared same clk;
//   lp_strobe in the same clk wins (lp stays 1).
//  Data write (cs&we&rs): push {index,db_in} into FIFO. FIFO drains one entry/clk while !busy.
//   Empty FIFO & !busy: write applied at next clk edge (1-clk latency, bypass).
//   Apply: index>=NUM_REGS -> discarded; EXT_MASK -> ext_wr pulse with ext_widx/ext_wdata;
//   else reg<=(db & IMPL) | (RESET_VAL & ~IMPL).
//   FIFO full & new write: write dropped, pend_ovf<=1 (cleared only by reset).
//   Writes apply strictly in issue order; a read never overtakes a pending write to the same reg.
//  Data read (cs&!we&rs): if busy or FIFO non-empty -> db_out unchanged (stalled read);
//   else db_out<= index>=NUM_REGS ? 8'hFF : EXT ? ext_rdata : reg | ~IMPL.
//  Auto-increment: if autoinc & index!=DATA_IDX, index+1 after each data access (even a stalled read),
//   wrapping NUM_REGS-1 -> 0. Pending FIFO entries carry their own index, unaffected.
//  Simultaneous index write and FIFO drain: drain uses stored index; no conflict.
//  reset_n asserted mid-drain: FIFO flushed, pending writes lost.
// TESTING
//  Reset: RESET_VAL[8*25+:8]=8'h47 -> regs reg25=8'h47, db_out=00, status read = {~busy,0,vsync,000,version}.
//  Write idx=26, data 8'hF0, busy=0 -> regs reg26=F0 one clk later; data read returns F0.
//  busy=1, write reg1=8'h50 then reg2=8'h66 -> regs unchanged; busy=0 -> reg1 then reg2 on consecutive clks.
//  busy=1, 3 writes with PEND_DEPTH=2 -> third dropped, pend_ovf=1; first two applied after busy falls.
//  IMPL_MASK reg5=8'h1F, write 8'hAA -> read 8'hEA; autoinc=1 idx=37 NUM_REGS=38 read -> idx=0.
//  lp_strobe coincident with status read -> db_out[6] per prior lp, lp remains 1; next status read clears it.

Source files
------------

// File: rtl/vdc_regbank_if.sv
// CPU bus of the VDC register bank: one-clock access strobe plus data in/out.
interface vdc_regbank_if;
  logic       cs;
  logic       rs;
  logic       we;
  logic [7:0] db_in;
  logic [7:0] db_out;

  modport master (output cs, output rs, output we, output db_in, input db_out);
  modport slave  (input cs, input rs, input we, input db_in, output db_out);
endinterface

// File: rtl/vdc_regbank.sv
// VDC CPU-side register bank: index/status registers, NUM_REGS control
// registers, a write-pending FIFO that defers data writes while the RAM
// engine is busy, optional index auto-increment and per-bit masks.
module vdc_regbank #(
  parameter int                    NUM_REGS   = 38,
  parameter int                    PEND_DEPTH = 2,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL  = {NUM_REGS*8{1'b0}},
  parameter logic [NUM_REGS*8-1:0] IMPL_MASK  = {NUM_REGS*8{1'b1}},
  parameter logic [NUM_REGS-1:0]   EXT_MASK   = {NUM_REGS{1'b0}},
  parameter int                    DATA_IDX   = 31
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vdc_regbank_if.slave            bus,
  input  logic [1:0]              version,
  input  logic                    autoinc,
  input  logic                    busy,
  input  logic                    vsync,
  input  logic                    lp_strobe,
  input  logic [7:0]              ext_rdata,
  output logic [7:0]              ext_idx,
  output logic                    ext_wr,
  output logic [7:0]              ext_widx,
  output logic [7:0]              ext_wdata,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic                    pend_ovf
);

  // Pointer width kept >= 1 so a depth-1 FIFO still has a legal pointer.
  localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CW = $clog2(PEND_DEPTH + 1);

  logic [7:0]            index_q, index_d;
  logic [7:0]            db_out_q, db_out_d;
  logic                  lp_q, lp_d;
  logic                  ovf_q, ovf_d;
  logic                  ext_wr_q, ext_wr_d;
  logic [7:0]            ext_widx_q, ext_widx_d;
  logic [7:0]            ext_wdata_q, ext_wdata_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [15:0]           fifo_mem [PEND_DEPTH];

  logic idx_wr, stat_rd, dat_wr, dat_rd;
  logic fifo_empty, fifo_full, pop, push, bypass, push_req;
  logic apply_vld;
  logic [15:0] apply_ent;
  logic [7:0]  apply_idx, apply_data;

  logic [NUM_REGS-1:0] wr_hit, ext_hit_vec, rd_hit;
  logic [7:0]          rd_word [NUM_REGS];
  logic [7:0]          rd_chain [NUM_REGS+1];
  logic                ext_hit;
  logic [7:0]          rd_val;

  assign idx_wr  = bus.cs &  bus.we & ~bus.rs;
  assign stat_rd = bus.cs & ~bus.we & ~bus.rs;
  assign dat_wr  = bus.cs &  bus.we &  bus.rs;
  assign dat_rd  = bus.cs & ~bus.we &  bus.rs;

  // FIFO control: drain one entry per clock while idle; an idle empty FIFO is bypassed.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(PEND_DEPTH));
    pop        = ~busy & ~fifo_empty;
    bypass     = dat_wr & ~busy & fifo_empty;
    push_req   = dat_wr & ~bypass;
    push       = push_req & (~fifo_full | pop);
    apply_vld  = pop | bypass;
    apply_ent  = pop ? fifo_mem[rd_ptr_q] : {index_q, bus.db_in};
    apply_idx  = apply_ent[15:8];
    apply_data = apply_ent[7:0];
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(PEND_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push)
      wr_ptr_d = (wr_ptr_q == PW'(PEND_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Per-register write enable, masked write data and read word.
  // Out-of-range indices match no register, so they are discarded / read FF.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign wr_hit[gi]      = apply_vld & (apply_idx == 8'(gi)) & ~EXT_MASK[gi];
    assign ext_hit_vec[gi] = apply_vld & (apply_idx == 8'(gi)) &  EXT_MASK[gi];
    assign rd_hit[gi]      = (index_q == 8'(gi));
    assign regs_d[gi*8 +: 8] = wr_hit[gi]
        ? ((apply_data & IMPL_MASK[gi*8 +: 8]) | (RESET_VAL[gi*8 +: 8] & ~IMPL_MASK[gi*8 +: 8]))
        : regs_q[gi*8 +: 8];
    assign rd_word[gi] = EXT_MASK[gi] ? ext_rdata : (regs_q[gi*8 +: 8] | ~IMPL_MASK[gi*8 +: 8]);
    assign rd_chain[gi+1] = rd_chain[gi] | (rd_hit[gi] ? rd_word[gi] : 8'h00);
  end
  assign rd_chain[0] = 8'h00;
  assign ext_hit     = |ext_hit_vec;
  assign rd_val      = (|rd_hit) ? rd_chain[NUM_REGS] : 8'hFF;

  // Next state of index, read data, light-pen latch, overflow flag and external strobe.
  always_comb begin
    index_d = index_q;
    if (idx_wr)
      index_d = bus.db_in;
    else if ((dat_wr || dat_rd) && autoinc && (index_q != 8'(DATA_IDX)))
      index_d = (index_q >= 8'(NUM_REGS - 1)) ? 8'h00 : index_q + 8'd1;

    db_out_d = db_out_q;
    if (stat_rd)
      db_out_d = {~busy, lp_q, vsync, 3'b000, version};
    else if (dat_rd && !busy && fifo_empty)
      db_out_d = rd_val;

    lp_d = lp_q;
    if (lp_strobe)
      lp_d = 1'b1;
    else if (stat_rd)
      lp_d = 1'b0;

    ovf_d       = ovf_q | (push_req & ~push);
    ext_wr_d    = ext_hit;
    ext_widx_d  = ext_hit ? apply_idx  : ext_widx_q;
    ext_wdata_d = ext_hit ? apply_data : ext_wdata_q;
  end

  // FIFO storage; contents need no reset since the count marks validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {index_q, bus.db_in};
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q     <= 8'h00;
      db_out_q    <= 8'h00;
      lp_q        <= 1'b0;
      ovf_q       <= 1'b0;
      ext_wr_q    <= 1'b0;
      ext_widx_q  <= 8'h00;
      ext_wdata_q <= 8'h00;
      regs_q      <= RESET_VAL;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      index_q     <= index_d;
      db_out_q    <= db_out_d;
      lp_q        <= lp_d;
      ovf_q       <= ovf_d;
      ext_wr_q    <= ext_wr_d;
      ext_widx_q  <= ext_widx_d;
      ext_wdata_q <= ext_wdata_d;
      regs_q      <= regs_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  assign bus.db_out = db_out_q;
  assign ext_idx    = index_q;
  assign ext_wr     = ext_wr_q;
  assign ext_widx   = ext_widx_q;
  assign ext_wdata  = ext_wdata_q;
  assign regs       = regs_q;
  assign pend_ovf   = ovf_q;

endmodule
